// File: rtl/digital_pll_lock_detect.sv
// Frequency-lock monitor for the digital PLL.
// Runs on the PLL output clock. It counts PLL cycles between rising edges of the
// reference oscillator and compares each count with the programmed divider.
// Lock is declared after LOCK_COUNT consecutive in-tolerance periods. Lock is
// dropped after UNLOCK_COUNT consecutive out-of-tolerance periods.
// A saturated period counter means the reference has stopped. This raises stall
// and forces the detector to re-prime.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | detector disabled; counters, locked and stall held clear
// PRIME   | waiting for a first osc edge to start a clean period count
// ACQUIRE | measuring periods, counting consecutive good ones toward lock
// LOCKED  | lock asserted, counting consecutive bad periods toward unlock
module digital_pll_lock_detect #(
  parameter int CNT_W        = 7,
  parameter int TOL          = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             osc_i,
  input  logic [4:0]       div_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] meas_o,
  output logic             meas_valid_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PC_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PC_ZERO = '0;
  localparam logic [CNT_W-1:0] PC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_COUNT);

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic             locked_q, locked_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             meas_valid_q, meas_valid_d;

  logic             osc_rise;
  logic             pc_sat;
  logic [CNT_W-1:0] pc_inc;
  logic [CNT_W:0]   pc_ext;
  logic [CNT_W:0]   div_ext;
  logic [CNT_W:0]   diff;
  logic             good;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;

  // Three-flop synchroniser for the asynchronous reference oscillator
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], osc_i};
    end
  end

  // Edge detect, counter helpers and the tolerance judgement on the current count
  always_comb begin
    osc_rise = sync_q[1] & ~sync_q[2];
    pc_sat   = (pc_q == PC_MAX);
    pc_inc   = pc_sat ? pc_q : (pc_q + PC_ONE);
    pc_ext   = {1'b0, pc_q};
    div_ext  = {{(CNT_W-4){1'b0}}, div_i};
    if (pc_ext >= div_ext) begin
      diff = pc_ext - div_ext;
    end else begin
      diff = div_ext - pc_ext;
    end
    // A divider below 2 cannot describe a real PLL ratio, so nothing is judged good
    good     = (div_i >= 5'd2) && (diff <= TOL_W);
    good_inc = good_cnt_q + 4'd1;
    bad_inc  = bad_cnt_q + 4'd1;
  end

  // Next-state and datapath decisions for the lock FSM
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    locked_d     = locked_q;
    stall_d      = stall_q;
    meas_d       = meas_q;
    meas_valid_d = 1'b0;

    if (!enable_i) begin
      // Disable overrides everything, including a coincident osc edge
      state_d    = IDLE;
      pc_d       = PC_ZERO;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
      locked_d   = 1'b0;
      stall_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_d       = PC_ZERO;
          good_cnt_d = 4'd0;
          bad_cnt_d  = 4'd0;
          locked_d   = 1'b0;
          stall_d    = 1'b0;
          state_d    = PRIME;
        end

        PRIME: begin
          if (osc_rise) begin
            // The count before the first edge covers an unknown interval, so it is discarded
            pc_d    = PC_ONE;
            stall_d = 1'b0;
            state_d = ACQUIRE;
          end else if (pc_sat) begin
            stall_d = 1'b1;
            pc_d    = PC_ZERO;
          end else begin
            pc_d = pc_inc;
          end
        end

        ACQUIRE, LOCKED: begin
          if (osc_rise) begin
            // An edge that coincides with saturation still counts as a measurement
            pc_d         = PC_ONE;
            meas_d       = pc_q;
            meas_valid_d = 1'b1;
            if (state_q == ACQUIRE) begin
              if (good) begin
                if (good_inc == LOCK_N) begin
                  state_d    = LOCKED;
                  locked_d   = 1'b1;
                  good_cnt_d = 4'd0;
                  bad_cnt_d  = 4'd0;
                end else begin
                  good_cnt_d = good_inc;
                end
              end else begin
                good_cnt_d = 4'd0;
              end
            end else begin
              if (good) begin
                bad_cnt_d = 4'd0;
              end else if (bad_inc == UNLOCK_N) begin
                state_d    = ACQUIRE;
                locked_d   = 1'b0;
                good_cnt_d = 4'd0;
                bad_cnt_d  = 4'd0;
              end else begin
                bad_cnt_d = bad_inc;
              end
            end
          end else if (pc_sat) begin
            // Reference has gone quiet: drop lock and wait for it to return
            stall_d    = 1'b1;
            locked_d   = 1'b0;
            pc_d       = PC_ZERO;
            good_cnt_d = 4'd0;
            bad_cnt_d  = 4'd0;
            state_d    = PRIME;
          end else begin
            pc_d = pc_inc;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= PC_ZERO;
      good_cnt_q   <= 4'd0;
      bad_cnt_q    <= 4'd0;
      locked_q     <= 1'b0;
      stall_q      <= 1'b0;
      meas_q       <= PC_ZERO;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      locked_q     <= locked_d;
      stall_q      <= stall_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign locked_o     = locked_q;
  assign meas_o       = meas_q;
  assign meas_valid_o = meas_valid_q;
  assign stall_o      = stall_q;

endmodule
